// File: rtl/periph_pkg.sv
// periph_pkg: shared address map, register offsets, TCON bit indices, DIGI reset value and a register-hit helper
package periph_pkg;
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] OFF_TH      = 32'h00;
  localparam logic [31:0] OFF_TL      = 32'h04;
  localparam logic [31:0] OFF_TCON    = 32'h08;
  localparam logic [31:0] OFF_LED     = 32'h0C;
  localparam logic [31:0] OFF_DIGI    = 32'h10;
  localparam logic [31:0] OFF_SYSTICK = 32'h14;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
  localparam logic [11:0] DIGI_RST = 12'hFFF;
  function automatic logic is_reg(input logic [31:0] a, input logic [31:0] off);
    return {a[31:2], 2'b00} == PERIPH_BASE + off;
  endfunction
endpackage

// File: rtl/periph_timer.sv
// periph_timer: reloadable TH/TL timer with sticky status and level irq; ports clk, reset, wdata, th_we/tl_we/tcon_we in, th/tl/tcon/irq out
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic ovf;
  assign ovf = tcon[TCON_EN] && tl == 32'hFFFF_FFFF;
  assign irq = tcon[TCON_IE] & tcon[TCON_ST];
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (th_we) th <= wdata;
      tl <= tl_we ? wdata : ovf ? th : tcon[TCON_EN] ? tl + 32'd1 : tl;
      tcon[1:0] <= tcon_we ? wdata[1:0] : tcon[1:0];
      tcon[TCON_ST] <= tcon_we ? wdata[TCON_ST] | (ovf & wdata[TCON_IE])
                               : tcon[TCON_ST] | (ovf & tcon[TCON_IE]);
    end
  end
endmodule

// File: rtl/periph_bus.sv
// periph_bus: data-bus responder decoding RAM and timer/LED/DIGI/SYSTICK page; ports clk, reset, addr, wdata, mem_read, mem_write in, rdata, led, an, digital_tube, irq out
module periph_bus
  import periph_pkg::*;
#(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [3:0]  an,
  output logic [7:0]  digital_tube,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] th, tl, systick, rd;
  logic [2:0]  tcon;
  logic [11:0] digi;
  logic        ram_hit;
  logic [AW-1:0] idx;
  assign ram_hit = addr[31:AW+2] == RAM_BASE[31:AW+2];
  assign idx = addr[AW+1:2];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
      led     <= '0;
      digi    <= DIGI_RST;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (mem_write && ram_hit) ram[idx] <= wdata;
      if (mem_write && is_reg(addr, OFF_LED)) led <= wdata[7:0];
      if (mem_write && is_reg(addr, OFF_DIGI)) digi <= wdata[11:0];
    end
  end
  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wdata   (wdata),
    .th_we   (mem_write && is_reg(addr, OFF_TH)),
    .tl_we   (mem_write && is_reg(addr, OFF_TL)),
    .tcon_we (mem_write && is_reg(addr, OFF_TCON)),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );
  always_comb
    rd = ram_hit                    ? ram[idx] :
         is_reg(addr, OFF_TH)      ? th :
         is_reg(addr, OFF_TL)      ? tl :
         is_reg(addr, OFF_TCON)    ? {29'b0, tcon} :
         is_reg(addr, OFF_LED)     ? {24'b0, led} :
         is_reg(addr, OFF_DIGI)    ? {20'b0, digi} :
         is_reg(addr, OFF_SYSTICK) ? systick : '0;
  assign rdata = mem_read ? rd : '0;
  assign an = digi[11:8];
  assign digital_tube = digi[7:0];
endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: directed self-checking bench for periph_bus
module tb_periph_bus;
  localparam logic [31:0] TH = 32'h4000_0000, TL = 32'h4000_0004, TCON = 32'h4000_0008;
  localparam logic [31:0] LED = 32'h4000_000C, DIGI = 32'h4000_0010, SYS = 32'h4000_0014;
  logic clk = 0, reset = 1, mem_read = 0, mem_write = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, tick;
  logic [7:0] led, digital_tube;
  logic [3:0] an;
  logic irq;
  int vectors = 0, errs = 0;
  periph_bus #(.RAM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_read(mem_read),
    .mem_write(mem_write), .rdata(rdata), .led(led), .an(an),
    .digital_tube(digital_tube), .irq(irq)
  );
  always #50 clk = ~clk;
  always @(posedge clk) tick <= reset ? 32'd0 : tick + 32'd1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    addr = a;
    mem_read = 1;
    #1;
    chk(tag, rdata, e);
    mem_read = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_write = 1;
    @(negedge clk);
    mem_write = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_led", {24'b0, led}, 32'h00);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_tube", {24'b0, digital_tube}, 32'hFF);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd(TH, 0, "rst_th");
    rd(TL, 0, "rst_tl");
    rd(TCON, 0, "rst_tcon");
    rd(LED, 0, "rst_ledreg");
    rd(DIGI, 32'hFFF, "rst_digi");
    rd(32'h10, 0, "rst_ram");
    rd(SYS, 0, "rst_systick0");
    @(negedge clk);
    rd(SYS, 1, "systick1");
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h3FC, 32'h1234_5678);
    rd(32'h10, 32'hDEAD_BEEF, "ram_10");
    rd(32'h3FC, 32'h1234_5678, "ram_3fc");
    rd(32'h13, 32'hDEAD_BEEF, "ram_13");
    rd(32'h2000_0000, 0, "unmapped");
    rd(32'h400, 0, "ram_past_end");
    addr = 32'h10;
    #1;
    chk("no_read_strobe", rdata, 0);
    wdata = 32'h1;
    mem_read = 1;
    mem_write = 1;
    #1;
    chk("rw_old_value", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_write = 0;
    chk("rw_new_value", rdata, 32'h1);
    mem_read = 0;
    wr(TH, 32'hFFFF_FFFC);
    wr(TL, 32'hFFFF_FFFE);
    wr(TCON, 32'h3);
    rd(TL, 32'hFFFF_FFFE, "tl_start");
    @(negedge clk);
    rd(TL, 32'hFFFF_FFFF, "tl_max");
    chk("irq_before_ovf", {31'b0, irq}, 0);
    @(negedge clk);
    rd(TL, 32'hFFFF_FFFC, "tl_reload");
    chk("irq_on_ovf", {31'b0, irq}, 1);
    rd(TCON, 32'h7, "tcon_status");
    @(negedge clk);
    rd(TL, 32'hFFFF_FFFD, "tl_after_reload");
    wr(TCON, 32'h3);
    chk("irq_cleared", {31'b0, irq}, 0);
    rd(TCON, 32'h3, "tcon_cleared");
    rd(TL, 32'hFFFF_FFFE, "tl_counting");
    @(negedge clk);
    wr(TCON, 32'h3);
    chk("race_tcon_irq", {31'b0, irq}, 1);
    rd(TCON, 32'h7, "race_tcon_status");
    rd(TL, 32'hFFFF_FFFC, "race_tcon_tl");
    repeat (3) @(negedge clk);
    wr(TL, 32'h5);
    rd(TL, 32'h5, "race_tl_write");
    wr(TL, 32'hFFFF_FFFF);
    wr(TH, 32'h10);
    rd(TL, 32'hFFFF_FFFC, "race_th_old");
    rd(TH, 32'h10, "race_th_new");
    chk("irq_still_high", {31'b0, irq}, 1);
    wr(LED, 32'hA5);
    chk("led_out", {24'b0, led}, 32'hA5);
    wr(DIGI, 32'h0EC0);
    chk("an_out", {28'b0, an}, 32'hE);
    chk("tube_out", {24'b0, digital_tube}, 32'hC0);
    rd(DIGI, 32'hEC0, "digi_reg");
    wr(SYS, 32'h0);
    rd(SYS, tick, "systick_write_ignored");
    reset = 1;
    @(negedge clk);
    reset = 0;
    rd(TL, 0, "midrst_tl");
    rd(TCON, 0, "midrst_tcon");
    chk("midrst_irq", {31'b0, irq}, 0);
    rd(32'h10, 0, "midrst_ram");
    chk("midrst_led", {24'b0, led}, 0);
    rd(SYS, 0, "midrst_systick");
    @(negedge clk);
    rd(TL, 0, "midrst_tl_hold");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
